// File: rtl/bag_dispenser.sv
// bag_dispenser: takes completed 7-piece bags from the bag filler into a local
// buffer, pulses newbag to clear the filler, and serves pieces one at a time
// over a request/valid handshake with a one-piece preview. A fresh bag is
// loaded on the same edge that pops the last piece, so bags chain without a gap.
module bag_dispenser #(
  parameter logic [2:0] NONE_CODE = 3'b111,
  parameter int         BAG_N     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bag_done,
  input  logic [3*BAG_N-1:0]   bag,
  output logic                 newbag,
  input  logic                 piece_req,
  output logic [2:0]           piece,
  output logic                 piece_valid,
  output logic [2:0]           next_piece,
  output logic [2:0]           remaining,
  output logic                 underrun,
  output logic                 bag_err
);

  localparam int W = 3 * BAG_N;

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  logic [W-1:0] cur_q, cur_d;
  logic [2:0]   count_q, count_d;
  logic [1:0]   state_q, state_d;
  logic         newbag_q, newbag_d;
  logic         underrun_q, underrun_d;
  logic         bag_err_q, bag_err_d;

  logic         pop;
  logic         load_ok;
  logic         bag_bad;
  logic [2:0]   bag_code [BAG_N];

  // Unpack the incoming bag into individual piece codes for the validity check.
  genvar gi;
  generate
    for (gi = 0; gi < BAG_N; gi++) begin : g_code
      assign bag_code[gi] = bag[3*gi +: 3];
    end
  endgenerate

  // A bag is bad if it holds the empty code or repeats any code; with seven
  // slots and no repeats among 0..6 it is necessarily a permutation.
  always_comb begin
    logic [7:0] seen;
    logic       dup;
    seen = '0;
    dup  = 1'b0;
    for (int i = 0; i < BAG_N; i++) begin
      if (seen[bag_code[i]]) dup = 1'b1;
      seen[bag_code[i]] = 1'b1;
    end
    bag_bad = dup | seen[NONE_CODE];
  end

  assign piece_valid = (count_q != 3'd0);
  assign piece       = cur_q[2:0];
  assign remaining   = count_q;
  assign newbag      = newbag_q;
  assign underrun    = underrun_q;
  assign bag_err     = bag_err_q;

  assign pop = piece_req && piece_valid;

  // Loads are blocked during S_CLEAR: bag_done may still read high there
  // because the filler's clear has not propagated yet.
  assign load_ok = bag_done && (state_q != S_CLEAR) &&
                   ((count_q == 3'd0) || ((count_q == 3'd1) && pop));

  // Preview: second buffered piece, else the head of a bag about to load.
  always_comb begin
    next_piece = NONE_CODE;
    if (count_q >= 3'd2)
      next_piece = cur_q[5:3];
    else if (bag_done && (state_q != S_CLEAR))
      next_piece = bag[2:0];
  end

  // Next-state: load takes priority (it also consumes the final pop), else shift.
  always_comb begin
    cur_d      = cur_q;
    count_d    = count_q;
    state_d    = state_q;
    newbag_d   = 1'b0;
    bag_err_d  = bag_err_q;
    underrun_d = piece_req && !piece_valid;
    if (load_ok) begin
      cur_d     = bag;
      count_d   = 3'(BAG_N);
      newbag_d  = 1'b1;
      state_d   = S_CLEAR;
      bag_err_d = bag_err_q | bag_bad;
    end else if (pop) begin
      cur_d   = {NONE_CODE, cur_q[W-1:3]};
      count_d = count_q - 3'd1;
      state_d = (count_q == 3'd1) ? S_WAIT : S_SERVE;
    end else if (state_q == S_CLEAR) begin
      state_d = S_SERVE;
    end
  end

  // State registers; reset discards everything at once, including newbag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q      <= {BAG_N{NONE_CODE}};
      count_q    <= 3'd0;
      state_q    <= S_WAIT;
      newbag_q   <= 1'b0;
      underrun_q <= 1'b0;
      bag_err_q  <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      count_q    <= count_d;
      state_q    <= state_d;
      newbag_q   <= newbag_d;
      underrun_q <= underrun_d;
      bag_err_q  <= bag_err_d;
    end
  end

endmodule

// File: tb/tb_bag_dispenser.sv
// Testbench for bag_dispenser: a queue of expected pieces is filled when a bag
// is offered for loading and drained as pieces are popped.
module tb_bag_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        bag_done;
  logic [20:0] bag;
  logic        newbag;
  logic        piece_req;
  logic [2:0]  piece;
  logic        piece_valid;
  logic [2:0]  next_piece;
  logic [2:0]  remaining;
  logic        underrun;
  logic        bag_err;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q [$];

  bag_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .bag_done    (bag_done),
    .bag         (bag),
    .newbag      (newbag),
    .piece_req   (piece_req),
    .piece       (piece),
    .piece_valid (piece_valid),
    .next_piece  (next_piece),
    .remaining   (remaining),
    .underrun    (underrun),
    .bag_err     (bag_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a bag and record its pieces in load order.
  task automatic offer_bag(input logic [20:0] b);
    bag      = b;
    bag_done = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back(b[3*i +: 3]);
    $display("load bag=%07o", b);
  endtask

  // Pop one piece and compare it against the scoreboard.
  task automatic pop_one();
    logic [2:0] e;
    piece_req = 1'b1;
    checks++;
    if (exp_q.size() == 0 || piece_valid !== 1'b1) begin
      failures++;
      $display("FAIL pop_valid got valid=%0b need valid=1 queue=%0d", piece_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      $display("pop piece=%0d expected=%0d", piece, e);
      if (piece !== e) begin
        failures++;
        $display("FAIL pop_piece got=%0d need=%0d", piece, e);
      end
    end
    tick();
    piece_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic test_reset();
    bag_done = 1'b0; bag = '0; piece_req = 1'b0;
    reset = 1'b1;
    #12;
    checks++;
    if ({piece, piece_valid, remaining, newbag, next_piece, bag_err} !== {3'd7, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals got piece=%0d v=%0b rem=%0d nb=%0b nxt=%0d err=%0b need 7 0 0 0 7 0",
               piece, piece_valid, remaining, newbag, next_piece, bag_err);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_bag();
    offer_bag(21'o6543210);
    tick();
    bag_done = 1'b0;
    checks++;
    if ({piece_valid, piece, next_piece, remaining, newbag} !== {1'b1, 3'd0, 3'd1, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL single_load got v=%0b p=%0d nxt=%0d rem=%0d nb=%0b need 1 0 1 7 1",
               piece_valid, piece, next_piece, remaining, newbag);
    end
    tick();
    checks++;
    if (newbag !== 1'b0 || remaining !== 3'd7) begin
      failures++;
      $display("FAIL single_newbag_pulse got nb=%0b rem=%0d need 0 7", newbag, remaining);
    end
    for (int i = 0; i < 7; i++) pop_one();
    checks++;
    if (piece_valid !== 1'b0 || piece !== 3'd7 || remaining !== 3'd0) begin
      failures++;
      $display("FAIL single_empty got v=%0b p=%0d rem=%0d need 0 7 0", piece_valid, piece, remaining);
    end
  endtask

  task automatic test_back_to_back();
    offer_bag(21'o6543210);
    tick();
    bag_done = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) pop_one();
    checks++;
    if (remaining !== 3'd1) begin
      failures++;
      $display("FAIL b2b_rem1 got=%0d need=1", remaining);
    end
    offer_bag(21'o0123456);
    #1;
    checks++;
    if (next_piece !== 3'd6) begin
      failures++;
      $display("FAIL b2b_preview got=%0d need=6", next_piece);
    end
    pop_one();
    bag_done = 1'b0;
    checks++;
    if ({piece_valid, piece, remaining, newbag} !== {1'b1, 3'd6, 3'd7, 1'b1}) begin
      failures++;
      $display("FAIL b2b_chain got v=%0b p=%0d rem=%0d nb=%0b need 1 6 7 1",
               piece_valid, piece, remaining, newbag);
    end
    tick();
    checks++;
    if (newbag !== 1'b0) begin
      failures++;
      $display("FAIL b2b_single_pulse got nb=%0b need 0", newbag);
    end
    for (int i = 0; i < 7; i++) pop_one();
    checks++;
    if (remaining !== 3'd0 || bag_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end got rem=%0d err=%0b need 0 0", remaining, bag_err);
    end
  endtask

  task automatic test_underrun();
    piece_req = 1'b1;
    tick();
    piece_req = 1'b0;
    checks++;
    if ({underrun, remaining, piece, newbag} !== {1'b1, 3'd0, 3'd7, 1'b0}) begin
      failures++;
      $display("FAIL underrun_pulse got u=%0b rem=%0d p=%0d nb=%0b need 1 0 7 0",
               underrun, remaining, piece, newbag);
    end
    tick();
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL underrun_clear got=%0b need=0", underrun);
    end
  endtask

  task automatic test_clear_hold();
    offer_bag(21'o3456012);
    tick();
    checks++;
    if (newbag !== 1'b1 || remaining !== 3'd7) begin
      failures++;
      $display("FAIL hold_load got nb=%0b rem=%0d need 1 7", newbag, remaining);
    end
    pop_one();
    checks++;
    if (remaining !== 3'd6 || newbag !== 1'b0) begin
      failures++;
      $display("FAIL hold_clear_pop got rem=%0d nb=%0b need 6 0", remaining, newbag);
    end
    tick();
    bag_done = 1'b0;
    checks++;
    if (remaining !== 3'd6 || newbag !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_reload got rem=%0d nb=%0b need 6 0", remaining, newbag);
    end
    for (int i = 0; i < 6; i++) pop_one();
  endtask

  task automatic test_bag_err();
    offer_bag(21'o0000000);
    tick();
    bag_done = 1'b0;
    checks++;
    if (bag_err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%0b need=1", bag_err);
    end
    tick();
    for (int i = 0; i < 7; i++) pop_one();
    offer_bag(21'o1026543);
    tick();
    bag_done = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) pop_one();
    checks++;
    if (bag_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%0b need=1", bag_err);
    end
    do_reset();
    checks++;
    if (bag_err !== 1'b0) begin
      failures++;
      $display("FAIL err_reset got=%0b need=0", bag_err);
    end
  endtask

  task automatic test_async_reset();
    offer_bag(21'o6543210);
    tick();
    bag_done = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({piece, piece_valid, remaining, newbag, next_piece} !== {3'd7, 1'b0, 3'd0, 1'b0, 3'd7}) begin
      failures++;
      $display("FAIL async_reset got p=%0d v=%0b rem=%0d nb=%0b nxt=%0d need 7 0 0 0 7",
               piece, piece_valid, remaining, newbag, next_piece);
    end
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_bag();
    test_back_to_back();
    test_underrun();
    test_clear_hold();
    test_bag_err();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
